// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter
//   Shares one I2C master controller between N_REQ local requesters. A
//   requester presents a descriptor (7-bit address, direction, byte count);
//   one requester is granted at a time. The block launches the transaction on
//   the master's start interface, then routes write-data requests, read bytes
//   and completion back to the granted requester only.
//
//   Build option: define I2C_ARB_RR_EN for round-robin arbitration (search
//   upward from the last granted index, wrapping). Without it, arbitration is
//   fixed priority and the lowest requesting index wins.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   req_valid/rnw    per-requester pending flag and direction (1 = read)
//   req_addr/size    per-requester address [7i+6:7i] and byte count-1 [2i+1:2i]
//   req_ack          one-cycle pulse when the descriptor is captured
//   wr_req           master dataReq forwarded to the granted requester
//   wr_data/valid    per-requester write byte and its valid
//   rd_data          last read byte (shared)
//   rd_valid         one-cycle pulse to the granted requester per read byte
//   done             one-cycle pulse to the granted requester at the end
//   grant_busy       high from grant until done
//   m_*              master start/descriptor/write-data outputs and
//                    busy/dataReq/newData/data_o inputs
module i2c_req_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_rnw,
  input  logic [7*N_REQ-1:0]   req_addr,
  input  logic [2*N_REQ-1:0]   req_size,
  output logic [N_REQ-1:0]     req_ack,
  output logic [N_REQ-1:0]     wr_req,
  input  logic [8*N_REQ-1:0]   wr_data,
  input  logic [N_REQ-1:0]     wr_valid,
  output logic [7:0]           rd_data,
  output logic [N_REQ-1:0]     rd_valid,
  output logic [N_REQ-1:0]     done,
  output logic                 grant_busy,
  output logic                 m_start,
  output logic [6:0]           m_addr,
  output logic                 m_rnw,
  output logic [1:0]           m_size,
  output logic [7:0]           m_data_i,
  output logic                 m_data_valid,
  input  logic                 m_busy,
  input  logic                 m_dataReq,
  input  logic                 m_newData,
  input  logic [7:0]           m_data_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_ACTIVE, S_DONE
  } state_t;

  state_t             r_state, w_next;
  logic [PTR_W-1:0]   r_g;
  logic [PTR_W-1:0]   w_win;
  logic [N_REQ-1:0]   w_g_oh;
  logic [N_REQ-1:0]   r_req_ack;
  logic [N_REQ-1:0]   r_rd_valid;
  logic [7:0]         r_rd_data;
  logic [6:0]         r_addr;
  logic               r_rnw;
  logic [1:0]         r_size;
  logic               r_busy_q;
  logic               r_nd_q;
  logic               w_nd_fall;
  logic               w_grant;

  assign w_g_oh  = N_REQ'(1) << r_g;
  assign w_grant = (r_state == S_IDLE) && (|req_valid);
  // m_data_o is only stable once newData has been high for a while, so the
  // byte is taken on the falling edge of newData.
  assign w_nd_fall = r_nd_q && !m_newData;

  // ---------------------------------------------------------------- arbiter
`ifdef I2C_ARB_RR_EN
  logic [PTR_W-1:0] r_last;

  // Walk candidates from farthest (last itself) to nearest (last+1); the final
  // hit is the nearest requester after last, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    w_win = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(r_last) + k) % N_REQ;
      if (req_valid[idx]) w_win = PTR_W'(idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_last <= PTR_W'(N_REQ - 1);
    else if (r_state == S_DONE) r_last <= r_g;
  end
`else
  always_comb begin
    w_win = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req_valid[i]) w_win = PTR_W'(i);
  end
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (|req_valid) w_next = S_LAUNCH;
      S_LAUNCH:    w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (m_busy) w_next = S_ACTIVE;
      // busy seen high on the previous edge and low now: transaction over
      S_ACTIVE:    if (r_busy_q && !m_busy) w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ routed outputs
  always_comb begin
    m_start      = 1'b0;
    grant_busy   = 1'b0;
    done         = '0;
    wr_req       = '0;
    m_data_i     = '0;
    m_data_valid = 1'b0;
    case (r_state)
      S_LAUNCH: begin
        m_start    = 1'b1;
        grant_busy = 1'b1;
      end
      S_WAIT_BUSY: grant_busy = 1'b1;
      S_ACTIVE: begin
        grant_busy   = 1'b1;
        wr_req       = m_dataReq ? w_g_oh : '0;
        m_data_i     = wr_data[{r_g, 3'b000} +: 8];
        m_data_valid = wr_valid[r_g];
      end
      S_DONE: begin
        grant_busy = 1'b1;
        done       = w_g_oh;
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------- captured state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_g        <= '0;
      r_req_ack  <= '0;
      r_rd_valid <= '0;
      r_rd_data  <= '0;
      r_addr     <= '0;
      r_rnw      <= 1'b0;
      r_size     <= '0;
      r_busy_q   <= 1'b0;
      r_nd_q     <= 1'b0;
    end else begin
      r_busy_q   <= m_busy;
      r_nd_q     <= m_newData;
      r_req_ack  <= '0;
      r_rd_valid <= '0;
      if (w_grant) begin
        r_g       <= w_win;
        r_addr    <= req_addr[7*int'(w_win) +: 7];
        r_rnw     <= req_rnw[w_win];
        r_size    <= req_size[2*int'(w_win) +: 2];
        r_req_ack <= N_REQ'(1) << w_win;
      end
      if (r_state == S_ACTIVE && w_nd_fall) begin
        r_rd_data  <= m_data_o;
        r_rd_valid <= w_g_oh;
      end
    end
  end

  assign req_ack  = r_req_ack;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign m_addr   = r_addr;
  assign m_rnw    = r_rnw;
  assign m_size   = r_size;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: stimulus tasks push expected
// launches, read bytes and completions into queues; a negedge monitor pops
// and compares whenever the DUT presents m_start, rd_valid or done.
module tb_i2c_req_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_rnw;
  logic [7*N-1:0] req_addr;
  logic [2*N-1:0] req_size;
  logic [N-1:0]   req_ack, wr_req, rd_valid, done;
  logic [8*N-1:0] wr_data = '0;
  logic [N-1:0]   wr_valid = '0;
  logic [7:0]     rd_data;
  logic           grant_busy, m_start, m_rnw, m_data_valid;
  logic [6:0]     m_addr;
  logic [1:0]     m_size;
  logic [7:0]     m_data_i;
  logic           m_busy = 1'b0, m_dataReq = 1'b0, m_newData = 1'b0;
  logic [7:0]     m_data_o = '0;

  logic [6:0] addr_a [N];
  logic       rnw_a  [N];
  logic [1:0] size_a [N];
  logic [7:0] bytes  [4];

  always_comb begin
    req_addr = '0;
    req_rnw  = '0;
    req_size = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[7*i +: 7] = addr_a[i];
      req_rnw[i]         = rnw_a[i];
      req_size[2*i +: 2] = size_a[i];
    end
  end

  i2c_req_arbiter #(.N_REQ(N), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_size(req_size), .req_ack(req_ack),
    .wr_req(wr_req), .wr_data(wr_data), .wr_valid(wr_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .grant_busy(grant_busy), .m_start(m_start), .m_addr(m_addr),
    .m_rnw(m_rnw), .m_size(m_size), .m_data_i(m_data_i),
    .m_data_valid(m_data_valid), .m_busy(m_busy), .m_dataReq(m_dataReq),
    .m_newData(m_newData), .m_data_o(m_data_o)
  );

  typedef struct packed {
    logic [6:0]   a;
    logic         r;
    logic [1:0]   s;
    logic [N-1:0] oh;
  } launch_t;

  launch_t      lq[$];
  logic [11:0]  rq[$];
  logic [N-1:0] dq[$];

  int n_chk = 0, n_fail = 0, done_cnt = 0, cur_g = 0;
  bit wr_chk_en = 1'b0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ------------------------------------------------------------ monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (m_start) begin
        if (lq.size() == 0) chk("m_start_unexpected", 64'(m_start), 64'(0));
        else begin
          launch_t e;
          e = lq.pop_front();
          chk("launch_desc", 64'({m_addr, m_rnw, m_size}), 64'({e.a, e.r, e.s}));
          chk("req_ack", 64'(req_ack), 64'(e.oh));
          chk("grant_busy_launch", 64'(grant_busy), 64'(1));
        end
      end
      if (|rd_valid) begin
        if (rq.size() == 0) chk("rd_valid_unexpected", 64'(rd_valid), 64'(0));
        else begin
          logic [11:0] r;
          r = rq.pop_front();
          chk("rd_valid", 64'(rd_valid), 64'(r[11:8]));
          chk("rd_data", 64'(rd_data), 64'(r[7:0]));
        end
      end
      if (|done) begin
        done_cnt++;
        if (dq.size() == 0) chk("done_unexpected", 64'(done), 64'(0));
        else begin
          logic [N-1:0] d;
          d = dq.pop_front();
          chk("done", 64'(done), 64'(d));
          chk("grant_busy_done", 64'(grant_busy), 64'(1));
        end
      end
      if (wr_chk_en) begin
        chk("wr_req", 64'(wr_req), m_dataReq ? 64'(1 << cur_g) : 64'(0));
        chk("m_data_valid", 64'(m_data_valid), 64'(wr_valid[cur_g]));
        if (wr_valid[cur_g])
          chk("m_data_i", 64'(m_data_i), 64'(wr_data[cur_g*8 +: 8]));
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic wait_start(output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (m_start) return;
    end
    n_chk++; n_fail++;
    $display("FAIL start_timeout: no m_start within 40 cycles");
    cyc = -1;
  endtask

  // One transaction for expected winner g; requesters in vmask are pending.
  // noise: drop req_valid[g] in ACTIVE and drive requester 3's write port.
  task automatic do_txn(input int g, input logic [N-1:0] vmask, input bit noise);
    int cyc, d0;
    launch_t e;
    e.a = addr_a[g]; e.r = rnw_a[g]; e.s = size_a[g]; e.oh = N'(1 << g);
    lq.push_back(e);
    req_valid = vmask;
    wait_start(cyc);
    if (cyc < 0) return;
    chk("ack_latency", 64'(cyc), 64'(1));
    cur_g = g;
    if (!noise) req_valid = '0;
    repeat (2) @(posedge clk);
    #1 m_busy = 1'b1;
    @(posedge clk); #1;
    wr_chk_en = 1'b1;
    if (noise) req_valid = '0;
    for (int b = 0; b <= int'(e.s); b++) begin
      if (!e.r) begin
        if (noise) begin
          wr_valid[3] = 1'b1; wr_data[3*8 +: 8] = 8'hEE; m_dataReq = 1'b1;
          @(posedge clk); #1;
          wr_valid[3] = 1'b0;
        end
        wr_data[g*8 +: 8] = bytes[b]; wr_valid[g] = 1'b1; m_dataReq = 1'b1;
        @(posedge clk); #1;
        m_dataReq = 1'b0; wr_valid = '0;
        @(posedge clk); #1;
      end else begin
        m_newData = 1'b1;
        @(posedge clk); #1;
        m_data_o = bytes[b];
        rq.push_back({e.oh, bytes[b]});
        repeat (3) @(posedge clk); #1;
        m_newData = 1'b0;
        repeat (3) @(posedge clk); #1;
      end
    end
    wr_chk_en = 1'b0;
    dq.push_back(e.oh);
    d0 = done_cnt;
    m_busy = 1'b0;
    for (int i = 0; i < 10 && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: requester %0d", g);
    end
    repeat (2) @(posedge clk); #1;
  endtask

  int sim_g[4];
  int wrap_g[2];
  int cyc;

  initial begin
`ifdef I2C_ARB_RR_EN
    sim_g = '{0, 1, 2, 3}; wrap_g = '{0, 2};
`else
    sim_g = '{0, 0, 0, 0}; wrap_g = '{0, 0};
`endif
    for (int i = 0; i < N; i++) begin
      addr_a[i] = 7'(7'h10 + i); rnw_a[i] = 1'b0; size_a[i] = 2'd0;
    end
    bytes = '{8'h5A, 8'h00, 8'h00, 8'h00};

    // reset state
    #3;
    chk("reset_outputs", 64'({req_ack, wr_req, rd_data, rd_valid, done, grant_busy,
        m_start, m_addr, m_rnw, m_size, m_data_i, m_data_valid}), 64'(0));
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", 64'(grant_busy), 64'(0));

    // all requesting at once, four transactions
    for (int k = 0; k < 4; k++) do_txn(sim_g[k], 4'b1111, 1'b0);
    // wrap from last grant 3 with 0101
    do_txn(wrap_g[0], 4'b0101, 1'b0);
    do_txn(wrap_g[1], 4'b0101, 1'b0);

    // single write, requester 1
    addr_a[1] = 7'h50; rnw_a[1] = 1'b0; size_a[1] = 2'd1;
    bytes = '{8'h11, 8'h22, 8'h00, 8'h00};
    do_txn(1, 4'b0010, 1'b0);

    // read, requester 2, four bytes
    addr_a[2] = 7'h2A; rnw_a[2] = 1'b1; size_a[2] = 2'd3;
    bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_txn(2, 4'b0100, 1'b0);

    // requester 1 drops req_valid mid-transaction, requester 3 drives noise
    addr_a[1] = 7'h51;
    bytes = '{8'h33, 8'h44, 8'h00, 8'h00};
    do_txn(1, 4'b0010, 1'b1);

    // reset in ACTIVE
    addr_a[2] = 7'h33; rnw_a[2] = 1'b0; size_a[2] = 2'd0;
    lq.push_back('{a: 7'h33, r: 1'b0, s: 2'd0, oh: 4'b0100});
    req_valid = 4'b0100;
    wait_start(cyc);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 m_busy = 1'b1;
    repeat (2) @(posedge clk); #1;
    wr_data[2*8 +: 8] = 8'h77; wr_valid[2] = 1'b1; m_dataReq = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("reset_midtxn_outputs", 64'({req_ack, wr_req, rd_data, rd_valid, done, grant_busy,
        m_start, m_addr, m_rnw, m_size, m_data_i, m_data_valid}), 64'(0));
    m_busy = 1'b0; m_dataReq = 1'b0; wr_valid = '0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_midreset", 64'(grant_busy), 64'(0));
    bytes = '{8'h99, 8'h00, 8'h00, 8'h00};
    do_txn(0, 4'b1111, 1'b0);

    chk("queues_empty", 64'(lq.size() + rq.size() + dq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares one I2C master controller between N_REQ local requesters.
- Accepts a transaction descriptor (address, direction, byte count) from each requester and grants one at a time.
- Launches the transaction on the master's start interface, then routes write-data requests, read bytes and completion back to the granted requester only.
- Sits between client logic and the I2C master; the master's clock divider and bus pins are untouched.

Parameters:
N_REQ, 4, number of requesters (2..8).
PTR_W, 2, grant index width; must equal clog2(N_REQ).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  N_REQ  level; requester i has a pending transaction
req_rnw  in  N_REQ  1 = read, 0 = write, per requester
req_addr  in  7*N_REQ  7-bit slave address, requester i at [7i+6:7i]
req_size  in  2*N_REQ  byte count minus 1 (0 = 1 byte, 3 = 4 bytes)
req_ack  out  N_REQ  one-clk pulse; descriptor captured, requester granted
wr_req  out  N_REQ  write-byte request, forwarded to granted requester only
wr_data  in  8*N_REQ  write byte per requester
wr_valid  in  N_REQ  write byte valid per requester
rd_data  out  8  last read byte, shared
rd_valid  out  N_REQ  one-clk pulse to granted requester; rd_data valid
done  out  N_REQ  one-clk pulse at transaction end
grant_busy  out  1  high from grant until done
m_start  out  1  to master start
m_addr  out  7  to master addr
m_rnw  out  1  to master read_nwrite
m_size  out  2  to master data_byte_size
m_data_i  out  8  to master data_i
m_data_valid  out  1  to master data_valid
m_busy  in  1  from master busy
m_dataReq  in  1  from master dataReq
m_newData  in  1  from master newData (level, one I2C bit period long)
m_data_o  in  8  from master data_o

Behaviour:
- Reset (async, rst high):
  - State = IDLE; grant pointer g = 0; round-robin last pointer = N_REQ-1.
  - All outputs 0; captured descriptor registers 0.
- States: IDLE, LAUNCH, WAIT_BUSY, ACTIVE, DONE.
- IDLE, any req_valid bit set at a clk edge:
  - g = arbitration winner; m_addr/m_rnw/m_size loaded from requester g; req_ack[g] pulses next cycle; go to LAUNCH.
  - The requester may change its descriptor after req_ack.
- LAUNCH: m_start = 1 for exactly one cycle -> WAIT_BUSY.
- WAIT_BUSY: hold until m_busy = 1 -> ACTIVE.
  - No timeout; the master itself waits for a free multi-master bus.
- ACTIVE:
  - Combinational routing: wr_req[g] = m_dataReq, other wr_req bits 0; m_data_i = wr_data[g]; m_data_valid = wr_valid[g].
  - Non-granted wr_valid/wr_data are ignored.
  - Read return: m_newData falling edge detected via one sync register; rd_data <= m_data_o and rd_valid[g] pulses one cycle later.
  - Sampling on the falling edge is mandatory: m_data_o updates only after newData has risen.
  - m_busy falling (registered sample 1 then 0) -> DONE.
- DONE: done[g] pulses one cycle; last pointer = g; -> IDLE.
  - A new grant is possible on the next edge, so minimum gap is 2 clks between done and the next m_start.
- grant_busy = 1 in LAUNCH, WAIT_BUSY, ACTIVE and DONE.
- Outside ACTIVE: m_data_valid = 0, m_data_i = 0, wr_req = 0.
- m_addr/m_rnw/m_size hold their captured values from LAUNCH through DONE.
- req_valid dropping after grant has no effect; the transaction completes.
- req_valid changes during non-IDLE states are ignored until IDLE.
- rd_valid count per transaction = m_size+1 for reads, 0 for writes. The block counts nothing itself; it only forwards.
- Reset mid-transaction: all outputs to 0 immediately; the master has its own reset.

Optional Feature:
- I2C_ARB_RR_EN defined: round-robin arbitration.
  - Winner is the first set req_valid bit searching upward from last+1, wrapping modulo N_REQ.
- Not defined: fixed priority; lowest index wins; last pointer unused.

Test Plan:
- Single write, req 1 (addr 0x50, rnw 0, size 1), master model raises m_dataReq twice -> req_ack[1] 1 clk after req_valid; m_start one pulse with m_addr=0x50 m_size=1; wr_req[1] mirrors m_dataReq; wr_req[0,2,3]=0; done[1] one cycle after m_busy fall observed.
- Read, req 2 (size 3), model gives four m_newData pulses with m_data_o 0xA1, 0xB2, 0xC3, 0xD4 -> four rd_valid[2] pulses, each after a newData falling edge, rd_data in that order; no rd_valid on other bits.
- Simultaneous req_valid=4'b1111 over four transactions -> RR build grants 0,1,2,3; fixed build grants 0 four times while req 0 stays asserted.
- RR wrap: last grant 3, req_valid=4'b0101 -> grant 0, then grant 2.
- req_valid[1] deasserted in ACTIVE and wr_valid[3] toggled by a non-granted requester -> transaction completes, done[1] pulses, m_data_valid unaffected by requester 3.
- rst asserted in ACTIVE -> all outputs 0 asynchronously; after release IDLE; first grant follows reset pointer (RR: requester 0 first).
